audio_i2s_tx: RTL and testbench

- Downstream companion of the SPI codec register loader.
- Once codec configuration reports done, streams 16-bit stereo PCM samples to the codec DAC as an I2S master (BCLK, WCLK, DIN), all generated from CLK_50.
- Upstream audio logic supplies samples through a one-deep valid/ready buffer.
- Underruns are flagged and replaced with silence.

---
 rtl/audio_i2s_tx.sv | 196 +++++++++++++++++++
 tb/tb_audio_i2s_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
// ------------
// I2S master transmitter for the codec DAC. After the SPI register loader
// reports that codec configuration is done, this block streams 16-bit stereo
// PCM frames. It generates BCLK, WCLK and DIN from CLK_50.
//
// Frame format: standard I2S, 32 BCLK per frame, 16 bits per slot, MSB
// first, with a one-bit delay after each WCLK edge.
//
// Ports:
//   CLK_50         in   system clock (50 MHz)
//   RESET_n        in   asynchronous active-low reset
//   iCFG_DONE      in   codec configuration complete (level, CLK_50 domain)
//   iL_DATA[15:0]  in   left sample, two's complement
//   iR_DATA[15:0]  in   right sample, two's complement
//   iVALID         in   sample pair valid
//   oREADY         out  one-deep sample buffer is empty
//   oBCLK          out  I2S bit clock
//   oWCLK          out  I2S word clock (0 = left slot, 1 = right slot)
//   oDIN           out  I2S serial data to the codec
//   oUNDERRUN      out  sticky: a frame was loaded from an empty buffer
//   iCLR_UNDERRUN  in   synchronous clear of oUNDERRUN
//   oRUN           out  transmitter state is RUN (this is the FSM state bit)
//   oMCLK          out  CLK_50/4 codec master clock; present only when the
//                       macro AUDIO_I2S_TX_MCLK_EN is defined
//
// Handshake: a pair is accepted on a CLK_50 rising edge where iVALID and
// oREADY are both 1. The upstream logic holds iL_DATA/iR_DATA stable while
// iVALID is high. oREADY falls the cycle after an accept. oREADY rises the
// cycle after the frame load that empties the buffer. oREADY never depends
// combinationally on iVALID.
//
// Parameters:
//   BCLK_DIV    CLK_50 cycles per BCLK half-period (>= 2)
//   FRAME_BITS  BCLK cycles per frame; fixed at 32

module audio_i2s_tx #(
  parameter int BCLK_DIV   = 16,
  parameter int FRAME_BITS = 32
) (
  input  logic        CLK_50,
  input  logic        RESET_n,
  input  logic        iCFG_DONE,
  input  logic [15:0] iL_DATA,
  input  logic [15:0] iR_DATA,
  input  logic        iVALID,
  output logic        oREADY,
  output logic        oBCLK,
  output logic        oWCLK,
  output logic        oDIN,
  output logic        oUNDERRUN,
  input  logic        iCLR_UNDERRUN,
  output logic        oRUN
`ifdef AUDIO_I2S_TX_MCLK_EN
  ,
  output logic        oMCLK
`endif
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BC_W  = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(FRAME_BITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DIV_W-1:0]      div_q;
  logic [BC_W-1:0]       bc_q;
  logic [BC_W-1:0]       bc_nxt;
  logic [BC_W-1:0]       bit_idx;
  logic                  bclk_q, wclk_q, din_q;
  logic                  ready_q;
  logic                  underrun_q;
  logic [FRAME_BITS-1:0] buf_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [FRAME_BITS-1:0] frame_nxt;
  logic                  term_cnt, fall_ev, wrap_ev, load_ev, accept;

  // Divider terminal count. The divider only runs in RUN.
  assign term_cnt = (state_q == RUN) && (div_q == DIV_LAST);
  // A toggle while BCLK is high is the falling edge. All data and WCLK
  // updates happen on this edge.
  assign fall_ev  = term_cnt && bclk_q;
  assign bc_nxt   = bc_q + BC_W'(1);
  assign wrap_ev  = fall_ev && (bc_q == BC_LAST);
  // Frame load happens on the fall where bc becomes 1.
  assign load_ev  = fall_ev && (bc_q == '0);
  assign accept   = iVALID && ready_q;

  // The load uses the buffer state from before this edge. An empty buffer
  // loads silence, even if a pair is accepted on this same edge.
  assign frame_nxt = load_ev ? (ready_q ? '0 : buf_q) : frame_q;

  // One-bit delay: at bc=k the output is F[32-k]. At bc=0 this becomes F[0],
  // the right LSB of the frame just finishing. Modulo-32 negation gives both
  // cases with one index.
  assign bit_idx = BC_W'(0) - bc_nxt;

  // ---------------- FSM ----------------
  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (iCFG_DONE) state_d = RUN;
      RUN:  if (wrap_ev && !iCFG_DONE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- buffer / underrun ----------------
  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      buf_q      <= '0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      if (accept) buf_q <= {iL_DATA, iR_DATA};

      if (load_ev && !ready_q) ready_q <= 1'b1;
      else if (accept)         ready_q <= 1'b0;

      // A new underrun takes priority over a clear on the same edge.
      if (load_ev && ready_q) underrun_q <= 1'b1;
      else if (iCLR_UNDERRUN) underrun_q <= 1'b0;

      frame_q <= frame_nxt;
    end
  end

  // ---------------- bit clock, word clock, serial data ----------------
  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      div_q  <= '0;
      bc_q   <= '0;
      bclk_q <= 1'b0;
      wclk_q <= 1'b0;
      din_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
      wclk_q <= 1'b0;
      din_q  <= 1'b0;
      // On entry to RUN, park bc at the last count. The first fall event
      // (2*BCLK_DIV cycles later) then wraps it to 0, and the first frame
      // load follows one BCLK after that.
      bc_q   <= iCFG_DONE ? BC_LAST : '0;
    end else if (term_cnt) begin
      div_q <= '0;
      if (state_d == IDLE) begin
        // Configuration dropped. Stop at the frame boundary.
        bclk_q <= 1'b0;
        wclk_q <= 1'b0;
        din_q  <= 1'b0;
        bc_q   <= '0;
      end else begin
        bclk_q <= ~bclk_q;
        if (bclk_q) begin
          bc_q   <= bc_nxt;
          wclk_q <= bc_nxt[BC_W-1];
          din_q  <= frame_nxt[bit_idx];
        end
      end
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign oBCLK     = bclk_q;
  assign oWCLK     = wclk_q;
  assign oDIN      = din_q;
  assign oREADY    = ready_q;
  assign oUNDERRUN = underrun_q;
  assign oRUN      = (state_q == RUN);

`ifdef AUDIO_I2S_TX_MCLK_EN
  // Free-running master clock for the codec PLL. It runs before and during
  // SPI configuration.
  logic [1:0] mclk_cnt;
  always_ff @(posedge CLK_50 or negedge RESET_n) begin
    if (!RESET_n) mclk_cnt <= 2'd0;
    else          mclk_cnt <= mclk_cnt + 2'd1;
  end
  assign oMCLK = mclk_cnt[1];
`endif

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Testbench for audio_i2s_tx (BCLK_DIV = 16).
// When AUDIO_I2S_TX_MCLK_EN is defined, oMCLK is also checked.
module tb_audio_i2s_tx;

  logic        CLK_50 = 1'b0;
  logic        RESET_n = 1'b0;
  logic        iCFG_DONE = 1'b0;
  logic [15:0] iL_DATA = '0;
  logic [15:0] iR_DATA = '0;
  logic        iVALID = 1'b0;
  logic        iCLR_UNDERRUN = 1'b0;
  logic        oREADY, oBCLK, oWCLK, oDIN, oUNDERRUN, oRUN;
`ifdef AUDIO_I2S_TX_MCLK_EN
  logic        oMCLK;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic meas_en = 1'b0;

  audio_i2s_tx #(.BCLK_DIV(16)) dut (
    .CLK_50(CLK_50),
    .RESET_n(RESET_n),
    .iCFG_DONE(iCFG_DONE),
    .iL_DATA(iL_DATA),
    .iR_DATA(iR_DATA),
    .iVALID(iVALID),
    .oREADY(oREADY),
    .oBCLK(oBCLK),
    .oWCLK(oWCLK),
    .oDIN(oDIN),
    .oUNDERRUN(oUNDERRUN),
    .iCLR_UNDERRUN(iCLR_UNDERRUN),
    .oRUN(oRUN)
`ifdef AUDIO_I2S_TX_MCLK_EN
    ,
    .oMCLK(oMCLK)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #10 CLK_50 = ~CLK_50;
  always @(posedge CLK_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_50);
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int g = 0;
    while (!oREADY && g < 3000) begin
      @(negedge CLK_50);
      g++;
    end
    check("send_ready", 32'(oREADY), 32'd1);
    if (oREADY) exp_q.push_back({l, r});
    iL_DATA = l;
    iR_DATA = r;
    iVALID  = 1'b1;
    @(negedge CLK_50);
    iVALID = 1'b0;
    check("ready_after_accept", 32'(oREADY), 32'd0);
  endtask

  // Hold iVALID high and count accepts. The next data word is presented
  // only after the current one has been taken.
  task automatic hold_stream(input int n_acc, input bit inc);
    logic [15:0] l, r;
    int acc = 0;
    int g = 0;
    int last_acc = -1;
    l = inc ? 16'h8001 : 16'hA5C3;
    r = inc ? 16'h7F00 : 16'h0F81;
    iL_DATA = l;
    iR_DATA = r;
    iVALID  = 1'b1;
    while (acc < n_acc && g < 12000) begin
      if (oREADY) begin
        exp_q.push_back({l, r});
        @(negedge CLK_50);
        g++;
        acc++;
        if (last_acc >= 0) check("accept_interval", cyc - last_acc, 1024);
        last_acc = cyc;
        check("ready_drop", 32'(oREADY), 32'd0);
        if (inc) begin
          l = l + 16'd1;
          r = r + 16'd3;
          iL_DATA = l;
          iR_DATA = r;
        end
      end else begin
        @(negedge CLK_50);
        g++;
      end
    end
    iVALID = 1'b0;
    check("stream_accepts", acc, n_acc);
  endtask

  // ---------------- scoreboard: I2S deserializer ----------------
  // oDIN is captured on each BCLK rising edge. A frame word is complete on
  // the first rising edge after WCLK falls. Because of the one-bit delay,
  // that edge carries the right LSB. The first BCLK cycle after entering
  // RUN comes before the first fall event, so its bit is not part of the
  // frame and is discarded.
  initial begin
    logic [31:0] sr;
    int nbits;
    logic pw, pb, skip;
    sr = '0; nbits = 0; pw = 1'b0; pb = 1'b0; skip = 1'b1;
    forever begin
      @(negedge CLK_50);
      if (!RESET_n) begin
        nbits = 0; pw = 1'b0; pb = 1'b0; skip = 1'b1;
      end else begin
        if (!oRUN) skip = 1'b1;
        if (oBCLK && !pb) begin
          if (skip) skip = 1'b0;
          else begin
            sr = {sr[30:0], oDIN};
            if (nbits < 32) nbits++;
            if (!oWCLK && pw && nbits >= 32 && exp_q.size() > 0)
              check("frame_word", sr, exp_q.pop_front());
            pw = oWCLK;
          end
        end
        pb = oBCLK;
      end
    end
  end

  // ---------------- timing monitor (active during streaming) ----------------
  initial begin
    int last_br, last_wf;
    logic pb, pw, pr;
    last_br = -1; last_wf = -1; pb = 1'b0; pw = 1'b0; pr = 1'b1;
    forever begin
      @(negedge CLK_50);
      if (meas_en) begin
        if (oBCLK && !pb) begin
          if (last_br >= 0) check("bclk_period", cyc - last_br, 32);
          last_br = cyc;
        end
        if (!oWCLK && pw) begin
          if (last_wf >= 0) check("wclk_period", cyc - last_wf, 1024);
          last_wf = cyc;
        end
        // The buffer empties at the load, which is one BCLK after WCLK falls.
        if (oREADY && !pr && last_wf >= 0) check("ready_rise_at_load", cyc - last_wf, 32);
      end
      pb = oBCLK; pw = oWCLK; pr = oREADY;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int g, s, t_und, t_load, bad;
    // Reset values
    tick(2);
    check("rst_bclk", 32'(oBCLK), 32'd0);
    check("rst_wclk", 32'(oWCLK), 32'd0);
    check("rst_din", 32'(oDIN), 32'd0);
    check("rst_ready", 32'(oREADY), 32'd1);
    check("rst_underrun", 32'(oUNDERRUN), 32'd0);
    check("rst_run", 32'(oRUN), 32'd0);
    RESET_n = 1'b1;
    tick(200);
    check("idle_bclk", 32'(oBCLK), 32'd0);
    check("idle_run", 32'(oRUN), 32'd0);

`ifdef AUDIO_I2S_TX_MCLK_EN
    begin
      int last_mr, rises;
      logic pm;
      last_mr = -1; rises = 0; pm = oMCLK;
      repeat (24) begin
        @(negedge CLK_50);
        if (oMCLK && !pm) begin
          if (last_mr >= 0) check("mclk_period", cyc - last_mr, 4);
          last_mr = cyc;
          rises++;
        end
        pm = oMCLK;
      end
      check("mclk_toggles", rises, 6);
    end
`endif

    // A pair accepted in IDLE is carried by the first RUN frame.
    send_pair(16'hA5C3, 16'h0F81);
    check("idle_still", 32'(oRUN), 32'd0);
    iCFG_DONE = 1'b1;
    tick(1);
    check("run_entry", 32'(oRUN), 32'd1);
    s = cyc;
    g = 0;
    while (!oBCLK && g < 100) begin @(negedge CLK_50); g++; end
    while (oBCLK && g < 200) begin @(negedge CLK_50); g++; end
    check("first_fall", cyc - s, 32);

    // Streaming: a fixed pattern, then an incrementing pattern with iVALID held.
    meas_en = 1'b1;
    hold_stream(3, 1'b0);
    hold_stream(8, 1'b1);
    meas_en = 1'b0;

    // Underrun: the last pair is still buffered. The frame after it is silent.
    g = 0;
    while (!oUNDERRUN && g < 3000) begin @(negedge CLK_50); g++; end
    check("underrun_set", 32'(oUNDERRUN), 32'd1);
    t_und = cyc;
    exp_q.push_back(32'h0);
    check("ready_at_underrun", 32'(oREADY), 32'd1);
    tick(10);
    iCLR_UNDERRUN = 1'b1;
    tick(1);
    iCLR_UNDERRUN = 1'b0;
    check("underrun_clear", 32'(oUNDERRUN), 32'd0);
    while (cyc < t_und + 1023) @(negedge CLK_50);
    check("underrun_still_clear", 32'(oUNDERRUN), 32'd0);
    iCLR_UNDERRUN = 1'b1;  // coincides with the next empty-buffer load
    tick(1);
    iCLR_UNDERRUN = 1'b0;
    check("underrun_set_wins", 32'(oUNDERRUN), 32'd1);
    exp_q.push_back(32'h0);

    // Recover with data, then drop configuration at bc=5.
    send_pair(16'h1234, 16'hFEDD);
    g = 0;
    while (!oREADY && g < 2000) begin @(negedge CLK_50); g++; end
    t_load = cyc;
    check("load_after_underrun", t_load - t_und, 2048);
    send_pair(16'h8000, 16'h0001);
    while (cyc < t_load + 128) @(negedge CLK_50);
    iCFG_DONE = 1'b0;
    g = 0;
    while (oRUN && g < 1200) begin @(negedge CLK_50); g++; end
    check("stop_at_wrap", cyc - t_load, 992);
    check("stop_bclk", 32'(oBCLK), 32'd0);
    check("stop_wclk", 32'(oWCLK), 32'd0);
    check("stop_din", 32'(oDIN), 32'd0);
    check("buffer_kept", 32'(oREADY), 32'd0);
    tick(100);
    check("stopped_bclk", 32'(oBCLK), 32'd0);
    iCFG_DONE = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 4000) begin @(negedge CLK_50); g++; end
    check("all_frames_seen", exp_q.size(), 0);

    // Reset while RUN, then stay idle with iCFG_DONE low.
    tick(300);
    check("pre_reset_run", 32'(oRUN), 32'd1);
    RESET_n = 1'b0;
    iCFG_DONE = 1'b0;
    #1;
    check("mid_rst_bclk", 32'(oBCLK), 32'd0);
    check("mid_rst_wclk", 32'(oWCLK), 32'd0);
    check("mid_rst_din", 32'(oDIN), 32'd0);
    check("mid_rst_ready", 32'(oREADY), 32'd1);
    check("mid_rst_underrun", 32'(oUNDERRUN), 32'd0);
    check("mid_rst_run", 32'(oRUN), 32'd0);
    tick(3);
    RESET_n = 1'b1;
    bad = 0;
    repeat (10000) begin
      @(negedge CLK_50);
      if (oBCLK || oRUN) bad++;
    end
    check("idle_10000", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
